sram_req_rsp: RTL
=================

# sram_req_rsp

Single-port on-chip SRAM with a valid/ready request channel, byte-enable writes, a selectable read-during-write mode, an in-order 2-deep response buffer that tolerates consumer backpressure, and a hardware clear engine. It replaces the bare synchronous RAM wrapper wherever the core's load/store or instruction-fetch paths need backpressure and a deterministic memory state after reset.

## Interface
- ADDR_WIDTH, 8, word address width; DEPTH = 2**ADDR_WIDTH words.
- DATA_WIDTH, 64, word width; must be a multiple of 8; BE_WIDTH = DATA_WIDTH/8.
- RD_MODE, 0, write response content: 0 = old word (read-first), 1 = merged new word (write-first).
- CLEAR_ON_RESET, 1, 1 = zero the whole array after reset release; 0 = array contents undefined after reset.

- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready at a rising edge.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  DATA_WIDTH  write data.
- req_be  in  BE_WIDTH  byte enables; bit i covers bits [8i+7:8i].
- clear_req  in  1  single-cycle pulse; starts a full-array clear.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready at a rising edge.
- rsp_rdata  out  DATA_WIDTH  response data.
- init_busy  out  1  clear engine running.

## Operation
- Every accepted request, read or write, yields exactly one response, in acceptance order.
- Read: rsp_rdata = word at req_addr at acceptance.
- Write: only bytes with req_be set are updated; req_be = 0 writes nothing but still responds. rsp_rdata = pre-write word (RD_MODE 0) or post-write merged word (RD_MODE 1).
- pending counter: accepted requests whose response has not been consumed, range 0..2. Increments on accept, decrements on consume, unchanged when both occur in the same cycle.
- req_ready = !init_busy && pending < 2, driven from registers only, with no combinational path from rsp_ready or req_valid.
- rsp_rdata is held stable while rsp_valid && !rsp_ready.
- Clear FSM states:
  - IDLE: moves to CLEAR on clear_req when init_busy = 0. clear_req during CLEAR is ignored.
  - CLEAR: one zero word written per cycle at addresses 0, 1, …, DEPTH-1 (counter ADDR_WIDTH+1 bits). Returns to IDLE after the edge that writes DEPTH-1.
- init_busy = 1 exactly in CLEAR, so no requests are accepted during a clear. Responses already pending still drain with their captured data, unaffected by the clear.

## Timing
- Reset values:
  - req_ready = !CLEAR_ON_RESET.
  - rsp_valid = 0.
  - rsp_rdata = 0.
  - init_busy = CLEAR_ON_RESET.
  - pending = 0.
  - FSM = CLEAR if CLEAR_ON_RESET, else IDLE.
  - Clear counter = 0.
- Reset asserted mid-operation: all pending responses are discarded; the clear restarts from address 0 when CLEAR_ON_RESET = 1. The array write port is inert while rst_n = 0.
- Clear duration: the first zero write lands on the first rising edge after rst_n deasserts (or after the clear_req edge). init_busy is high for exactly DEPTH cycles.
- Read latency: a request accepted at edge N gives rsp_valid = 1 after edge N (visible cycle N+1).
- Throughput: with rsp_ready held at 1, one request per cycle is sustained indefinitely.
- Backpressure: with rsp_ready = 0, at most 2 accepts occur, then req_ready falls after the second accept.
- Write at edge N followed by a read of the same address at edge N+1: the read returns the written data.

## Test plan
- Reset with CLEAR_ON_RESET=1, ADDR_WIDTH=4 -> init_busy high for 16 cycles; req_ready rises the cycle after; reading all 16 addresses returns 0.
- Write 0x1122334455667788 to address 5 with be=0xFF, then write 0xAAAAAAAAAAAAAAAA with be=0x0F -> RD_MODE 0: second write response = 0x1122334455667788; RD_MODE 1: 0x11223344AAAAAAAA; a subsequent read returns 0x11223344AAAAAAAA in both modes.
- Issue 4 back-to-back reads of addresses 0..3 (preloaded 0x10..0x13) with rsp_ready=0 -> only 2 accepted, rsp_rdata held at 0x10. Release rsp_ready -> responses 0x10, 0x11, 0x12, 0x13 in order, with no loss or duplication.
- Continuous reads with rsp_ready=1 -> req_ready never drops; one response per cycle, latency 1.
- Pulse clear_req with 2 responses pending -> both pending responses return their pre-clear data; req_ready stays 0 for DEPTH cycles; the array then reads 0.
- Assert rst_n low mid-clear and mid-burst -> rsp_valid is 0 immediately; after release, the clear restarts at address 0 and takes the full DEPTH cycles.

Source files
------------

// File: rtl/sram_req_rsp_if.sv
// Request/response bundle for sram_req_rsp.
// The master issues requests and consumes responses; the slave is the memory.
interface sram_req_rsp_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 64
) ();
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [BE_WIDTH-1:0]   req_be;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/sram_req_rsp.sv
// Single-port SRAM with valid/ready requests, byte-enable writes, an in-order
// two-entry response buffer and a word-per-cycle clear engine.
module sram_req_rsp #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 64,
    parameter int RD_MODE        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    sram_req_rsp_if.slave      bus,
    input  logic               clear_req,
    output logic               init_busy
);
    localparam int DEPTH    = 2 ** ADDR_WIDTH;
    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int CW       = ADDR_WIDTH + 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;

    state_t          state_reg, state_next;
    logic [CW-1:0]   clr_cnt_reg, clr_cnt_next;
    logic [1:0]      pending_reg, pending_next;
    logic            req_ready_reg;
    logic            accept;
    logic            consume;
    logic            clearing;

    // Storage and response datapath
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_old_reg;      // RAM output register (pre-write word)
    logic [DATA_WIDTH-1:0] rd_wdata_reg;    // write data of the newest request
    logic [BE_WIDTH-1:0]   rd_merge_be_reg; // lanes to overlay in write-first mode
    logic [DATA_WIDTH-1:0] rd_word;         // newest response word
    logic [DATA_WIDTH-1:0] skid_reg;        // older response when two are pending

    logic [BE_WIDTH-1:0]        wr_en;
    logic [BE_WIDTH-1:0][7:0]   wr_bytes;
    logic [ADDR_WIDTH-1:0]      wr_addr;

    assign clearing      = (state_reg == CLEAR);
    assign init_busy     = clearing;
    assign bus.req_ready = req_ready_reg;
    assign bus.rsp_valid = (pending_reg != 2'd0);
    assign accept        = bus.req_valid && req_ready_reg;
    assign consume       = bus.rsp_valid && bus.rsp_ready;

    // Clear FSM next state: walk the counter through every address once
    always_comb begin
        state_next   = state_reg;
        clr_cnt_next = clr_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (clear_req) begin
                    state_next   = CLEAR;
                    clr_cnt_next = '0;
                end
            end
            CLEAR: begin
                if (clr_cnt_reg == CW'(DEPTH - 1)) begin
                    state_next   = IDLE;
                    clr_cnt_next = '0;
                end else begin
                    clr_cnt_next = clr_cnt_reg + CW'(1);
                end
            end
            default: begin
                state_next   = IDLE;
                clr_cnt_next = '0;
            end
        endcase
    end

    // Outstanding-response count; simultaneous accept and consume cancel out
    always_comb begin
        pending_next = pending_reg;
        if (accept && !consume) begin
            pending_next = pending_reg + 2'd1;
        end else if (!accept && consume) begin
            pending_next = pending_reg - 2'd1;
        end
    end

    // Control registers; req_ready is precomputed so it never depends on inputs combinationally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= RESET_STATE;
            clr_cnt_reg   <= '0;
            pending_reg   <= '0;
            req_ready_reg <= (CLEAR_ON_RESET == 0);
        end else begin
            state_reg     <= state_next;
            clr_cnt_reg   <= clr_cnt_next;
            pending_reg   <= pending_next;
            req_ready_reg <= (state_next == IDLE) && (pending_next != 2'd2);
        end
    end

    // Per-lane write enables and data; the clear engine owns the port while busy
    assign wr_addr = clearing ? clr_cnt_reg[ADDR_WIDTH-1:0] : bus.req_addr;

    generate
        for (genvar gi = 0; gi < BE_WIDTH; gi++) begin : g_lane
            assign wr_en[gi]    = rst_n && (clearing ||
                                  (accept && bus.req_write && bus.req_be[gi]));
            assign wr_bytes[gi] = clearing ? 8'h00 : bus.req_wdata[8*gi +: 8];
            assign rd_word[8*gi +: 8] = rd_merge_be_reg[gi] ? rd_wdata_reg[8*gi +: 8]
                                                            : rd_old_reg[8*gi +: 8];
        end
    endgenerate

    // Array port: read-first registered read plus byte-lane writes
    always_ff @(posedge clk) begin
        for (int b = 0; b < BE_WIDTH; b++) begin
            if (wr_en[b]) begin
                mem[wr_addr][8*b +: 8] <= wr_bytes[b];
            end
        end
        if (accept) begin
            rd_old_reg      <= mem[bus.req_addr];
            rd_wdata_reg    <= bus.req_wdata;
            rd_merge_be_reg <= ((RD_MODE != 0) && bus.req_write) ? bus.req_be : '0;
        end
    end

    // Park the unconsumed older response before the RAM register is overwritten
    always_ff @(posedge clk) begin
        if (accept && (pending_reg == 2'd1) && !consume) begin
            skid_reg <= rd_word;
        end
    end

    // Head of the response queue: the parked entry is always the older one
    always_comb begin
        bus.rsp_rdata = '0;
        if (pending_reg == 2'd2) begin
            bus.rsp_rdata = skid_reg;
        end else if (pending_reg == 2'd1) begin
            bus.rsp_rdata = rd_word;
        end
    end
endmodule
